// File: rtl/instruction_fetch_controller.sv
// Instruction fetch controller for the RISC-V core.
// Owns the fetch PC and drives the combinational instruction memory. Each returned word is
// captured with its PC in a small in-order queue. The queue head is presented to decode over
// a valid/ready handshake. An aligned redirect flushes the queue and retargets the PC. A
// misaligned redirect flushes the queue and parks the block in a sticky error state, which
// only reset clears.

module instruction_fetch_controller #(
    parameter logic [63:0] RESET_PC    = 64'd0,
    parameter int unsigned QUEUE_DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         fetch_en,
    output logic [63:0]                  Inst_Address,
    input  logic [31:0]                  Instruction,
    input  logic                         redirect_valid,
    input  logic [63:0]                  redirect_pc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [31:0]                  out_instruction,
    output logic [63:0]                  out_pc,
    output logic [63:0]                  fetch_pc,
    output logic [$clog2(QUEUE_DEPTH):0] queue_count,
    output logic                         misaligned_err
);

    localparam int unsigned PtrW = $clog2(QUEUE_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    localparam logic [CntW-1:0] CntDepth = CntW'(QUEUE_DEPTH);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);
    localparam logic [PtrW-1:0] PtrOne   = PtrW'(1);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StError
    } state_e;

    state_e          state_q, state_d;
    logic [63:0]     pc_q, pc_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            err_q, err_d;

    // Queue storage: written only on push. The count gates every read, so no reset is needed.
    logic [63:0]     entry_pc_q    [QUEUE_DEPTH];
    logic [31:0]     entry_instr_q [QUEUE_DEPTH];

    logic            redirect_take;
    logic            redirect_bad;
    logic            queue_full;
    logic            pop;
    logic            push;

    // Handshake and qualifier decode shared by the next-state logic and the queue write.
    always_comb begin
        redirect_take = redirect_valid && (state_q != StError);
        redirect_bad  = redirect_take && (redirect_pc[1:0] != 2'b00);
        queue_full    = (count_q == CntDepth);
        pop           = out_valid && out_ready && !redirect_take;
        // A pop on the same edge frees a slot, so a full queue can still accept a word.
        push          = (state_q == StFetch) && fetch_en && !redirect_valid &&
                        (!queue_full || pop);
    end

    // Next-state for the FSM, fetch PC, queue pointers and sticky error flag.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        err_d    = err_q;

        if (redirect_take) begin
            // Flush wins over push and pop. A coincident head handshake is simply dropped.
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            if (redirect_bad) begin
                // Keep the old PC so the faulting context stays visible.
                state_d = StError;
                err_d   = 1'b1;
            end else begin
                pc_d = redirect_pc;
                if (state_q == StFetch && !fetch_en) begin
                    state_d = StIdle;
                end
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (fetch_en) begin
                        state_d = StFetch;
                    end
                end
                StFetch: begin
                    if (!fetch_en) begin
                        state_d = StIdle;
                    end
                end
                StError: begin
                    state_d = StError;
                end
                default: begin
                    state_d = StError;
                end
            endcase

            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrOne;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrOne;
                pc_d     = pc_q + 64'd4;
            end

            unique case ({push, pop})
                2'b10:   count_d = count_q + CntOne;
                2'b01:   count_d = count_q - CntOne;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= StIdle;
            pc_q     <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    // Capture the fetched word together with the address it came from.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            entry_pc_q[wr_ptr_q]    <= pc_q;
            entry_instr_q[wr_ptr_q] <= Instruction;
        end
    end

    // Present the queue head. Both data outputs read zero when the queue is empty.
    always_comb begin
        out_valid       = (count_q != '0) && (state_q != StError);
        out_pc          = '0;
        out_instruction = '0;
        if (out_valid) begin
            out_pc          = entry_pc_q[rd_ptr_q];
            out_instruction = entry_instr_q[rd_ptr_q];
        end
    end

    // The instruction memory is addressed directly by the registered fetch PC.
    always_comb begin
        Inst_Address   = pc_q;
        fetch_pc       = pc_q;
        queue_count    = count_q;
        misaligned_err = err_q;
    end

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Self-checking bench for instruction_fetch_controller.
// A behavioural model keeps the expected fetch stream in a queue of {pc, word} entries. A
// monitor compares the DUT's outputs against that queue on every falling edge. Directed
// sequences come first, followed by a long randomized run.

module tb_instruction_fetch_controller;

    localparam int          DEPTH = 2;
    localparam logic [63:0] RPC   = 64'd0;

    logic                    clk;
    logic                    reset;
    logic                    fetch_en;
    logic [63:0]             Inst_Address;
    logic [31:0]             Instruction;
    logic                    redirect_valid;
    logic [63:0]             redirect_pc;
    logic                    out_valid;
    logic                    out_ready;
    logic [31:0]             out_instruction;
    logic [63:0]             out_pc;
    logic [63:0]             fetch_pc;
    logic [$clog2(DEPTH):0]  queue_count;
    logic                    misaligned_err;

    instruction_fetch_controller #(
        .RESET_PC    (RPC),
        .QUEUE_DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .fetch_en        (fetch_en),
        .Inst_Address    (Inst_Address),
        .Instruction     (Instruction),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instruction (out_instruction),
        .out_pc          (out_pc),
        .fetch_pc        (fetch_pc),
        .queue_count     (queue_count),
        .misaligned_err  (misaligned_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: four fixed program words, then a hash of the address.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        logic [31:0] w;
        if (a < 64'd16) begin
            case (a[3:2])
                2'd0:    w = 32'h0F05_3483;
                2'd1:    w = 32'h009A_84B3;
                2'd2:    w = 32'h0014_8493;
                default: w = 32'h0E95_3823;
            endcase
        end else begin
            w = (a[31:0] * 32'h9E37_79B1) ^ a[63:32];
        end
        return w;
    endfunction

    assign Instruction = mem_word(Inst_Address);

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: an in-order list of fetched words plus the fetch address and mode flags.
    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t      mq[$];
    logic [63:0] m_pc;
    bit          m_run;
    bit          m_halt;
    bit          m_err;
    bit          chk_en = 1'b0;

    always @(posedge clk) begin
        bit can_pop;
        bit do_push;
        if (!reset) begin
            mq.delete();
            m_pc   = RPC;
            m_run  = 1'b0;
            m_halt = 1'b0;
            m_err  = 1'b0;
            chk_en = 1'b1;
        end else if (chk_en && !m_halt) begin
            if (redirect_valid) begin
                mq.delete();
                if (redirect_pc[1:0] != 2'b00) begin
                    m_halt = 1'b1;
                    m_err  = 1'b1;
                end else begin
                    m_pc  = redirect_pc;
                    m_run = m_run && fetch_en;
                end
            end else begin
                can_pop = (mq.size() > 0) && out_ready;
                do_push = m_run && fetch_en && ((mq.size() < DEPTH) || can_pop);
                if (can_pop) void'(mq.pop_front());
                if (do_push) begin
                    mq.push_back('{pc: m_pc, instr: mem_word(m_pc)});
                    m_pc = m_pc + 64'd4;
                end
                m_run = fetch_en;
            end
        end
    end

    // Monitor: whenever the DUT shows a head it must be the oldest expected entry.
    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid", 64'(out_valid), 64'(mq.size() != 0));
            if (out_valid) begin
                if (mq.size() == 0) begin
                    check("unexpected_head", 64'(out_valid), 64'd0);
                end else begin
                    check("out_pc", out_pc, mq[0].pc);
                    check("out_instruction", 64'(out_instruction), 64'(mq[0].instr));
                end
            end else begin
                check("empty_out_pc", out_pc, 64'd0);
                check("empty_out_instruction", 64'(out_instruction), 64'd0);
            end
            check("queue_count", 64'(queue_count), 64'(mq.size()));
            check("fetch_pc", fetch_pc, m_pc);
            check("Inst_Address", Inst_Address, m_pc);
            check("misaligned_err", 64'(misaligned_err), 64'(m_err));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        fetch_en = 1'b0;
        out_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 64'd0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        fetch_en = 1'b0;
        out_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 64'd0;
        tick();
        tick();

        // Streaming fetch, one instruction per cycle.
        reset = 1'b1; fetch_en = 1'b1; out_ready = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            check("t1_pc", out_pc, 64'(i * 4));
            check("t1_instr", 64'(out_instruction), 64'(mem_word(64'(i * 4))));
        end

        // Backpressure fills the queue, then drains in order.
        do_reset();
        fetch_en = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        @(negedge clk);
        check("t2_count_full", 64'(queue_count), 64'd2);
        check("t2_pc_hold", fetch_pc, 64'd8);
        check("t2_head", out_pc, 64'd0);
        out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            tick();
            @(negedge clk);
            check("t2_order", out_pc, 64'(i * 4));
        end

        // Redirect while full flushes the queue.
        do_reset();
        fetch_en = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        redirect_valid = 1'b1; redirect_pc = 64'd12;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("t3_flush_valid", 64'(out_valid), 64'd0);
        check("t3_flush_count", 64'(queue_count), 64'd0);
        check("t3_target", fetch_pc, 64'd12);
        tick();
        @(negedge clk);
        check("t3_first_pc", out_pc, 64'd12);
        check("t3_first_instr", 64'(out_instruction), 64'h0E95_3823);

        // Misaligned redirect is sticky until reset.
        redirect_valid = 1'b1; redirect_pc = 64'h6;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("t4_err", 64'(misaligned_err), 64'd1);
        check("t4_valid", 64'(out_valid), 64'd0);
        check("t4_pc_hold", fetch_pc, 64'd16);
        tick();
        redirect_valid = 1'b1; redirect_pc = 64'd0;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("t4_ignored", fetch_pc, 64'd16);
        do_reset();
        @(negedge clk);
        check("t4_err_clear", 64'(misaligned_err), 64'd0);
        check("t4_reset_pc", fetch_pc, RPC);
        tick();
        @(negedge clk);
        check("t4_idle", fetch_pc, RPC);

        // Full queue with simultaneous push/pop, then drain once fetching stops.
        fetch_en = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            check("t5_count_steady", 64'(queue_count), 64'd2);
        end
        fetch_en = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        @(negedge clk);
        check("t5_drained", 64'(queue_count), 64'd0);
        check("t5_frozen", fetch_pc, 64'd24);

        // Reset mid-stream discards the queued entry.
        do_reset();
        fetch_en = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        reset = 1'b0;
        tick();
        @(negedge clk);
        check("t6_valid", 64'(out_valid), 64'd0);
        check("t6_count", 64'(queue_count), 64'd0);
        check("t6_pc", fetch_pc, RPC);
        check("t6_out_pc", out_pc, 64'd0);
        check("t6_out_instr", 64'(out_instruction), 64'd0);
        reset = 1'b1; fetch_en = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("t6_no_stale", 64'(out_valid), 64'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            int unsigned r;
            reset          = ($urandom_range(0, 99) >= 2);
            fetch_en       = ($urandom_range(0, 9) < 8);
            out_ready      = ($urandom_range(0, 9) < 6);
            redirect_valid = ($urandom_range(0, 99) < 6);
            r = $urandom_range(0, 15);
            if (r == 0) begin
                redirect_pc = (64'($urandom_range(0, 63)) << 2) | 64'($urandom_range(1, 3));
            end else if (r == 1) begin
                redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8;
            end else begin
                redirect_pc = 64'($urandom_range(0, 63)) << 2;
            end
            tick();
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
